// File: rtl/mem_port_sched_if.sv
// Bundle between the CPU/RAM side and the memory port scheduler.
// master = CPU + RAM environment, slave = scheduler.
interface mem_port_sched_if #(
  parameter int AW = 14,
  parameter int DW = 10
);
  logic          cpu_read1;
  logic          cpu_read2;
  logic          cpu_read3;
  logic          cpu_read4;
  logic [AW-1:0] cpu_addr1;
  logic [AW-1:0] cpu_addr2;
  logic [AW-1:0] cpu_addr3;
  logic [AW-1:0] cpu_addr4;
  logic [DW-1:0] cpu_rdata1;
  logic [DW-1:0] cpu_rdata2;
  logic [DW-1:0] cpu_rdata3;
  logic [DW-1:0] cpu_rdata4;
  logic          cpu_write;
  logic [AW-1:0] cpu_waddr;
  logic [DW-1:0] cpu_wdata;
  logic          stall;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport master (
    output cpu_read1, cpu_read2, cpu_read3, cpu_read4,
    output cpu_addr1, cpu_addr2, cpu_addr3, cpu_addr4,
    output cpu_write, cpu_waddr, cpu_wdata,
    output mem_rdata,
    input  cpu_rdata1, cpu_rdata2, cpu_rdata3, cpu_rdata4,
    input  stall, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  cpu_read1, cpu_read2, cpu_read3, cpu_read4,
    input  cpu_addr1, cpu_addr2, cpu_addr3, cpu_addr4,
    input  cpu_write, cpu_waddr, cpu_wdata,
    input  mem_rdata,
    output cpu_rdata1, cpu_rdata2, cpu_rdata3, cpu_rdata4,
    output stall, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_sched.sv
// Serialises four CPU read ports and one write port onto a
// single-port synchronous RAM, stalling the CPU until done.
module mem_port_sched #(
  parameter int AW = 14,
  parameter int DW = 10,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  mem_port_sched_if.slave bus,
  output logic [CW-1:0] stall_cnt
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]    state;
  logic [4:0]    pend;
  logic [4:0]    req;
  logic [4:0]    gnt;
  logic [4:0]    pend_nxt;
  logic [1:0]    gsel;
  logic          any_req;
  logic [AW-1:0] addr_q [4];
  logic [AW-1:0] waddr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_q [4];
  logic          rd_vld;
  logic [1:0]    rd_sel;
  logic          stall_w;
  logic          en_w;
  logic          we_w;
  logic [AW-1:0] addr_w;
  logic [DW-1:0] wdata_w;

  always_comb begin
    req = {bus.cpu_write, bus.cpu_read4, bus.cpu_read3,
           bus.cpu_read2, bus.cpu_read1};
    any_req = |req;
    // lowest pending bit wins: read1..read4, then write
    gnt = pend & (~pend + 5'd1);
    pend_nxt = pend & ~gnt;
    gsel = 2'd0;
    unique case (1'b1)
      gnt[1]:  gsel = 2'd1;
      gnt[2]:  gsel = 2'd2;
      gnt[3]:  gsel = 2'd3;
      default: gsel = 2'd0;
    endcase
  end

  always_comb begin
    stall_w = 1'b0;
    en_w    = 1'b0;
    we_w    = 1'b0;
    addr_w  = '0;
    wdata_w = '0;
    if (!rst) begin
      unique case (state)
        IDLE:  stall_w = any_req;
        ISSUE: begin
          stall_w = 1'b1;
          en_w    = |pend;
          if (gnt[4]) begin
            we_w    = 1'b1;
            addr_w  = waddr_q;
            wdata_w = wdata_q;
          end else if (|pend) begin
            addr_w  = addr_q[gsel];
          end
        end
        DRAIN: stall_w = 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.stall      = stall_w;
  assign bus.mem_en     = en_w;
  assign bus.mem_we     = we_w;
  assign bus.mem_addr   = addr_w;
  assign bus.mem_wdata  = wdata_w;
  assign bus.cpu_rdata1 = rdata_q[0];
  assign bus.cpu_rdata2 = rdata_q[1];
  assign bus.cpu_rdata3 = rdata_q[2];
  assign bus.cpu_rdata4 = rdata_q[3];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pend      <= '0;
      rd_vld    <= 1'b0;
      rd_sel    <= '0;
      stall_cnt <= '0;
      for (int i = 0; i < 4; i++) rdata_q[i] <= '0;
    end else begin
      rd_vld <= 1'b0;
      if (stall_w && !(&stall_cnt))
        stall_cnt <= stall_cnt + CW'(1);
      // read issued last cycle: RAM data is on mem_rdata now
      if (rd_vld)
        rdata_q[rd_sel] <= bus.mem_rdata;
      unique case (state)
        IDLE: begin
          if (any_req) begin
            pend      <= req;
            addr_q[0] <= bus.cpu_addr1;
            addr_q[1] <= bus.cpu_addr2;
            addr_q[2] <= bus.cpu_addr3;
            addr_q[3] <= bus.cpu_addr4;
            waddr_q   <= bus.cpu_waddr;
            wdata_q   <= bus.cpu_wdata;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          pend   <= pend_nxt;
          rd_vld <= |gnt[3:0];
          rd_sel <= gsel;
          if (pend_nxt == '0)
            state <= DRAIN;
        end
        DRAIN:   state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_sched.sv
// Scoreboard bench for mem_port_sched: RAM model, memory-op
// and completion queues checked by a negedge monitor.
module tb_mem_port_sched;

  localparam int AW = 14;
  localparam int DW = 10;
  localparam int CW = 16;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } op_t;

  typedef struct packed {
    logic [3:0][DW-1:0] rd;
    logic [7:0]         ns;
  } dn_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_sched_if #(.AW(AW), .DW(DW)) bus ();
  logic [CW-1:0] stall_cnt;

  mem_port_sched #(.AW(AW), .DW(DW), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .stall_cnt (stall_cnt)
  );

  mem_port_sched_if #(.AW(AW), .DW(DW)) sbus ();
  logic [3:0] sat_cnt;

  mem_port_sched #(.AW(AW), .DW(DW), .CW(4)) dut_sat (
    .clk       (clk),
    .rst       (rst),
    .bus       (sbus),
    .stall_cnt (sat_cnt)
  );

  assign sbus.cpu_read1 = 1'b1;
  assign sbus.cpu_read2 = 1'b0;
  assign sbus.cpu_read3 = 1'b0;
  assign sbus.cpu_read4 = 1'b0;
  assign sbus.cpu_addr1 = '0;
  assign sbus.cpu_addr2 = '0;
  assign sbus.cpu_addr3 = '0;
  assign sbus.cpu_addr4 = '0;
  assign sbus.cpu_write = 1'b0;
  assign sbus.cpu_waddr = '0;
  assign sbus.cpu_wdata = '0;
  assign sbus.mem_rdata = '0;

  bit [DW-1:0] ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata <= ram[bus.mem_addr];
    end
  end

  int checks = 0;
  int errors = 0;
  int done_n = 0;
  op_t opq[$];
  dn_t dq[$];
  bit [DW-1:0] mdl [int];
  logic [3:0][DW-1:0] sh = '0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic bit [DW-1:0] mget(input int a);
    return mdl.exists(a) ? mdl[a] : '0;
  endfunction

  // monitor: memory ops every cycle, completion on stall fall
  initial begin : monitor
    int scnt;
    int tot;
    op_t o;
    dn_t d;
    scnt = 0;
    tot  = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        scnt = 0;
        tot  = 0;
      end else begin
        if (bus.mem_en) begin
          if (opq.size() == 0) begin
            chk("unexpected_mem_en", 32'(bus.mem_addr), 32'hFFFF_FFFF);
          end else begin
            o = opq.pop_front();
            chk("mem_we", 32'(bus.mem_we), 32'(o.we));
            chk("mem_addr", 32'(bus.mem_addr), 32'(o.a));
            chk("mem_wdata", 32'(bus.mem_wdata), 32'(o.d));
          end
        end
        if (bus.stall) begin
          scnt++;
        end else if (scnt > 0) begin
          tot += scnt;
          if (dq.size() == 0) begin
            chk("unexpected_done", 32'(scnt), 32'hFFFF_FFFF);
          end else begin
            d = dq.pop_front();
            chk("stall_cycles", 32'(scnt), 32'(d.ns));
            chk("cpu_rdata1", 32'(bus.cpu_rdata1), 32'(d.rd[0]));
            chk("cpu_rdata2", 32'(bus.cpu_rdata2), 32'(d.rd[1]));
            chk("cpu_rdata3", 32'(bus.cpu_rdata3), 32'(d.rd[2]));
            chk("cpu_rdata4", 32'(bus.cpu_rdata4), 32'(d.rd[3]));
            chk("stall_cnt", 32'(stall_cnt), 32'(tot));
          end
          scnt = 0;
          done_n++;
        end
      end
    end
  end

  task automatic expect_seq(input logic [4:0] rq,
                            input logic [3:0][AW-1:0] a,
                            input logic [AW-1:0] wa,
                            input logic [DW-1:0] wd);
    dn_t d;
    int n;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      if (rq[i]) begin
        opq.push_back('{we: 1'b0, a: a[i], d: '0});
        sh[i] = mget(int'(a[i]));
        n++;
      end
    end
    if (rq[4]) begin
      opq.push_back('{we: 1'b1, a: wa, d: wd});
      mdl[int'(wa)] = wd;
      n++;
    end
    d.rd = sh;
    d.ns = 8'(n + 2);
    dq.push_back(d);
  endtask

  task automatic drive(input logic [4:0] rq,
                       input logic [3:0][AW-1:0] a,
                       input logic [AW-1:0] wa,
                       input logic [DW-1:0] wd);
    {bus.cpu_write, bus.cpu_read4, bus.cpu_read3,
     bus.cpu_read2, bus.cpu_read1} = rq;
    bus.cpu_addr1 = a[0];
    bus.cpu_addr2 = a[1];
    bus.cpu_addr3 = a[2];
    bus.cpu_addr4 = a[3];
    bus.cpu_waddr = wa;
    bus.cpu_wdata = wd;
  endtask

  task automatic wait_done();
    int st;
    int k;
    st = done_n;
    k  = 0;
    while (done_n == st && k < 30) begin
      @(posedge clk);
      k++;
    end
    if (done_n == st) chk("done_timeout", 32'(k), 32'd0);
    #1;
  endtask

  // call at posedge+1 with the DUT idle
  task automatic run_seq(input logic [4:0] rq,
                         input logic [3:0][AW-1:0] a,
                         input logic [AW-1:0] wa,
                         input logic [DW-1:0] wd);
    expect_seq(rq, a, wa, wd);
    drive(rq, a, wa, wd);
    @(posedge clk);
    #1;
    drive(5'b0, ~a, ~wa, ~wd);
    wait_done();
  endtask

  initial begin : main
    rst = 1'b1;
    drive(5'b11111, {14'h0103, 14'h0102, 14'h0101, 14'h0100},
          14'h0104, 10'h2AA);
    @(posedge clk);
    repeat (2) begin
      @(negedge clk);
      chk("rst_stall", 32'(bus.stall), 32'd0);
      chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
      chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
      chk("rst_rdata", 32'({bus.cpu_rdata1, bus.cpu_rdata2,
                            bus.cpu_rdata3}), 32'd0);
    end
    @(posedge clk);
    #1;
    expect_seq(5'b11111, {14'h0103, 14'h0102, 14'h0101, 14'h0100},
               14'h0104, 10'h2AA);
    rst = 1'b0;
    @(posedge clk);
    #1;
    drive(5'b0, '0, '0, '0);
    wait_done();

    run_seq(5'b10000, '0, 14'h2000, 10'h155);
    run_seq(5'b10000, '0, 14'h2001, 10'h0AA);
    run_seq(5'b10000, '0, 14'h2002, 10'h3FF);
    run_seq(5'b10000, '0, 14'h0040, 10'h001);
    run_seq(5'b00111, {14'h0, 14'h2002, 14'h2001, 14'h2000}, '0, '0);
    run_seq(5'b11111, {14'h0040, 14'h2002, 14'h2001, 14'h2000},
            14'h0040, 10'h123);
    run_seq(5'b01000, {14'h0040, 14'h0, 14'h0, 14'h0}, '0, '0);
    run_seq(5'b10000, '0, 14'h0005, 10'h3FF);
    run_seq(5'b00011, {14'h0, 14'h0, 14'h0005, 14'h0005}, '0, '0);
    run_seq(5'b11010, {14'h0005, 14'h0, 14'h2002, 14'h0},
            14'h2001, 10'h2AB);
    run_seq(5'b00111, {14'h0, 14'h2001, 14'h2002, 14'h0040}, '0, '0);

    // reset while read3 would be issuing
    opq.push_back('{we: 1'b0, a: 14'h2000, d: '0});
    opq.push_back('{we: 1'b0, a: 14'h2001, d: '0});
    drive(5'b00111, {14'h0, 14'h2002, 14'h2001, 14'h2000}, '0, '0);
    @(posedge clk);
    #1;
    drive(5'b0, '0, '0, '0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sh = '0;
    chk("midrst_ops_left", 32'(opq.size()), 32'd0);
    chk("midrst_dq_left", 32'(dq.size()), 32'd0);
    repeat (10) begin
      @(negedge clk);
      chk("idle_stall", 32'(bus.stall), 32'd0);
      chk("idle_mem_en", 32'(bus.mem_en), 32'd0);
      chk("idle_stall_cnt", 32'(stall_cnt), 32'd0);
      chk("midrst_rdata", 32'({bus.cpu_rdata1, bus.cpu_rdata2,
                               bus.cpu_rdata3}), 32'd0);
    end

    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("sat_reach", 32'(sat_cnt), 32'd15);
    repeat (8) @(negedge clk);
    chk("sat_hold", 32'(sat_cnt), 32'd15);

    chk("opq_empty", 32'(opq.size()), 32'd0);
    chk("dq_empty", 32'(dq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
